slave_responder: RTL and testbench
==================================

SLAVE_RESPONDER -- requirements
Module: slave_responder

Interface
REQ-001 Parameter DATA_W, default 32: width of wdata/rdata.
REQ-002 Parameter ADDR_W, default 32: width of addr.
REQ-003 Parameter DEPTH, default 16: number of storage words, power of two, at least 2.
REQ-004 Parameter LATENCY, default 4: cycles from read acceptance to resp, at least 1.
REQ-005 Parameter MAX_OUTSTANDING, default 2: read-queue capacity, range 1 to LATENCY.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req  in  1  requester (arbiter-granted master) presents a transaction.
REQ-009 cmd  in  1  0 = read, 1 = write; valid while req = 1.
REQ-010 addr  in  ADDR_W  byte address; valid while req = 1.
REQ-011 wdata  in  DATA_W  write data; valid while req = 1 and cmd = 1.
REQ-012 ack  out  1  transaction accepted at this rising edge.
REQ-013 resp  out  1  one-cycle read-response strobe.
REQ-014 rdata  out  DATA_W  read data, valid only while resp = 1.

Function
REQ-015 Acceptance SHALL occur at a rising edge where req = 1 and ack = 1; at most one per cycle.
REQ-016 ack SHALL be combinational: ack = req AND (pending < MAX_OUTSTANDING OR resp = 1) AND throttle_ok (REQ-029).
REQ-017 Word index SHALL be addr[log2(DEPTH)+1:2]; all other addr bits are ignored.
REQ-018 Accepted write: mem[index] <= wdata at the acceptance edge; no resp is generated.
REQ-019 Accepted read: mem[index] SHALL be sampled at the acceptance edge into a LATENCY-stage valid/data pipeline; pending increments.
REQ-020 resp SHALL be 1 for exactly one cycle, starting LATENCY cycles after the acceptance edge (LATENCY = 1 means the cycle right after acceptance).
REQ-021 Responses SHALL be in acceptance order; back-to-back reads produce back-to-back resp pulses.
REQ-022 rdata SHALL be 0 whenever resp = 0.
REQ-023 pending SHALL decrement in the resp cycle; simultaneous accept and retire leaves it unchanged.
REQ-024 Queue full (pending = MAX_OUTSTANDING, no resp this cycle): ack = 0; requester holds req, cmd, addr and wdata unchanged.
REQ-025 A write accepted after a read to the same index SHALL NOT alter that read's already-sampled data.

Reset
REQ-026 While rst = 1: ack = 0, resp = 0, rdata = 0, pending = 0, all pipeline valids = 0, all mem words = 0, throttle_ok = 1.
REQ-027 rst asserted mid-transaction SHALL immediately discard all pending reads; no resp is issued for them after release.
REQ-028 The first acceptance is possible at the first rising edge after rst deasserts.

Configuration
REQ-029 Macro SLAVE_RESPONDER_THROTTLE_EN defined: a throttle flop toggles on every acceptance, and throttle_ok = 0 in the cycle following each acceptance, so back-to-back accepts are impossible. Macro undefined: throttle_ok is constant 1 and no throttle flop is instantiated.

Verification
REQ-030 Write 0xDEADBEEF to addr 0x8, then read addr 0x8 the next cycle -> resp 4 cycles after the read accept, rdata = 0xDEADBEEF.
REQ-031 Three reads, req held continuously from cycle 0, defaults -> accepts at cycles 0 and 1, ack = 0 at cycles 2 and 3, third accept at cycle 4 (same cycle as the first resp); resp at 4, 5 and 8.
REQ-032 Read addr 0x40 and addr 0x0 after writing 0x1234 to 0x0 (DEPTH = 16) -> both return 0x1234 (aliasing).
REQ-033 Read 0x4 accepted, rst pulsed 2 cycles later -> resp never asserts, mem[1] = 0, ack = 0 during rst.
REQ-034 With SLAVE_RESPONDER_THROTTLE_EN and req held for 6 cycles -> ack pattern 1,0,1,0,1,0.
REQ-035 Read of index 3 accepted, write 0xFFFF to index 3 next cycle -> resp carries the old value of mem[3].

Source files
------------

// File: rtl/slave_responder.sv
// rtl/slave_responder.sv - memory-backed slave with in-order, fixed-latency read responses
// Optional feature macro: SLAVE_RESPONDER_THROTTLE_EN (forbids back-to-back acceptances)

module slave_responder #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int DEPTH           = 16,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              resp,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Storage and read pipeline state
    logic [DATA_W-1:0]  mem_q  [DEPTH];
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [CNT_W-1:0]   pending_q;
    logic [CNT_W-1:0]   pending_d;

    logic             throttle_ok;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             accept_rd;
    logic             accept_wr;
    logic             unused_addr;

    // Only the word-index bits select storage; upper bits alias and byte-lane bits are ignored
    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^addr;

    // The last pipeline stage is the response; its data stage is zero whenever it is not valid
    assign resp  = valid_q[LATENCY-1];
    assign rdata = data_q[LATENCY-1];

    // A retiring response frees its slot in the same cycle, so a full queue can still accept then
    assign ack = !rst && req && throttle_ok &&
                 ((pending_q < CNT_W'(MAX_OUTSTANDING)) || resp);

    assign accept    = ack;
    assign accept_rd = accept && !cmd;
    assign accept_wr = accept && cmd;

`ifdef SLAVE_RESPONDER_THROTTLE_EN
    logic throttle_q;

    // Flop is set by every acceptance and clears the following cycle, so it toggles per accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            throttle_q <= 1'b0;
        end else begin
            throttle_q <= accept;
        end
    end

    assign throttle_ok = !throttle_q;
`else
    assign throttle_ok = 1'b1;
`endif

    // Word storage: written on accepted writes, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept_wr) begin
            mem_q[idx] <= wdata;
        end
    end

    // Next valid vector: shift towards the response stage, new read enters stage 0
    always_comb begin
        valid_d = (valid_q << 1) | LATENCY'(accept_rd);
    end

    // Read pipeline: data is captured at acceptance so later writes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            data_q[0] <= accept_rd ? mem_q[idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Outstanding-read count: up on read acceptance, down on response, unchanged when both
    always_comb begin
        pending_d = pending_q;
        if (accept_rd && !resp) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!accept_rd && resp) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    // Outstanding-read counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_slave_responder.sv
// tb/tb_slave_responder.sv - self-checking bench for slave_responder (default parameters)

module tb_slave_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 4;
    localparam int MAXO  = 2;
    localparam int LOGN  = 2048;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        cmd   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    slave_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack), .resp(resp), .rdata(rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    bit          thr_m = 1'b0;

    bit          ack_log   [LOGN];
    bit          resp_log  [LOGN];
    logic [31:0] rdata_log [LOGN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: storage array plus a queue of responses each tagged with the cycle it is due.
    // Inputs are stable from #1 after a rising edge to the next, so the negedge sees them settled.
    always @(negedge clk) begin : model_and_compare
        bit          er;
        bit          ea;
        logic [31:0] ed;
        if (rst) begin
            q.delete();
            foreach (mem_m[i]) mem_m[i] = '0;
            thr_m = 1'b0;
        end
        er = !rst && (q.size() > 0) && (q[0].due == cyc);
        ed = er ? q[0].data : 32'h0;
        ea = !rst && req && ((q.size() < MAXO) || er);
`ifdef SLAVE_RESPONDER_THROTTLE_EN
        if (thr_m) ea = 1'b0;
`endif
        chk("ack", 32'(ack), 32'(ea));
        chk("resp", 32'(resp), 32'(er));
        chk("rdata", rdata, ed);
        if (cyc < LOGN) begin
            ack_log[cyc]   = ack;
            resp_log[cyc]  = resp;
            rdata_log[cyc] = rdata;
        end
        if (!rst) begin
            if (er) void'(q.pop_front());
            if (ea) begin
                if (cmd) begin
                    mem_m[addr[5:2]] = wdata;
                end else begin
                    q.push_back('{due: cyc + LAT, data: mem_m[addr[5:2]]});
                end
            end
            thr_m = ea;
        end
        cyc = cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one transaction and hold it until accepted; returns the acceptance cycle
    task automatic issue(input bit c, input logic [31:0] a, input logic [31:0] d, output int acc);
        int n;
        bit got;
        req   = 1'b1;
        cmd   = c;
        addr  = a;
        wdata = d;
        n     = 0;
        got   = 1'b0;
        acc   = -1;
        while (!got && n < 64) begin
            @(negedge clk);
            got = ack;
            @(posedge clk);
            #1;
            n++;
            if (got) acc = cyc - 1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got no ack expected ack within 64 cycles (addr %h)", a);
        end
        req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a0, a1, a2, t, s, cnt;
        logic [5:0] pat;

        // Reset held with a read request pending: nothing may be acknowledged
        rst  = 1'b1;
        req  = 1'b1;
        cmd  = 1'b0;
        addr = 32'h4;
        step(3);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_resp", 32'(resp), 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        // Write then read 0x8; first accept lands on the first edge after release
        rst = 1'b0;
        t   = cyc;
        issue(1'b1, 32'h8, 32'hDEADBEEF, a0);
        chk("first_accept_cycle", a0, t);
        issue(1'b0, 32'h8, 32'h0, a1);
`ifndef SLAVE_RESPONDER_THROTTLE_EN
        chk("read_after_write_cycle", a1, a0 + 1);
`endif
        step(8);
        chk("wr_rd_resp_early", 32'(resp_log[a1+3]), 32'h0);
        chk("wr_rd_resp", 32'(resp_log[a1+4]), 32'h1);
        chk("wr_rd_data", rdata_log[a1+4], 32'hDEADBEEF);

        // Three reads with the queue filling up
        issue(1'b0, 32'h0, 32'h0, a0);
        issue(1'b0, 32'h4, 32'h0, a1);
        issue(1'b0, 32'h8, 32'h0, a2);
        step(10);
`ifndef SLAVE_RESPONDER_THROTTLE_EN
        chk("acc1_cycle", a1 - a0, 32'd1);
        chk("acc2_cycle", a2 - a0, 32'd4);
        chk("full_ack_c2", 32'(ack_log[a0+2]), 32'h0);
        chk("full_ack_c3", 32'(ack_log[a0+3]), 32'h0);
        chk("resp_c4", 32'(resp_log[a0+4]), 32'h1);
        chk("resp_c5", 32'(resp_log[a0+5]), 32'h1);
        chk("resp_c6", 32'(resp_log[a0+6]), 32'h0);
        chk("rdata_c6", rdata_log[a0+6], 32'h0);
        chk("resp_c8", 32'(resp_log[a0+8]), 32'h1);
        chk("rdata_c8", rdata_log[a0+8], 32'hDEADBEEF);
`endif

        // Address aliasing: 0x40 maps onto word 0
        issue(1'b1, 32'h0, 32'h1234, t);
        issue(1'b0, 32'h40, 32'h0, a0);
        issue(1'b0, 32'h0, 32'h0, a1);
        step(10);
        chk("alias_0x40", rdata_log[a0+4], 32'h1234);
        chk("alias_0x0", rdata_log[a1+4], 32'h1234);

        // Write right behind a read of the same word does not reach that read
        issue(1'b1, 32'hC, 32'hAAAA5555, t);
        issue(1'b0, 32'hC, 32'h0, a0);
        issue(1'b1, 32'hC, 32'h0000FFFF, a1);
        step(8);
        chk("old_value_kept", rdata_log[a0+4], 32'hAAAA5555);
        issue(1'b0, 32'hC, 32'h0, a2);
        step(8);
        chk("new_value_seen", rdata_log[a2+4], 32'h0000FFFF);

        // Reset two cycles after a read acceptance discards it and clears storage
        issue(1'b1, 32'h4, 32'h77, t);
        issue(1'b0, 32'h4, 32'h0, a0);
        step(1);
        rst  = 1'b1;
        req  = 1'b1;
        cmd  = 1'b0;
        addr = 32'h4;
        t    = cyc;
        step(2);
        rst = 1'b0;
        req = 1'b0;
        step(10);
        chk("midrst_ack0", 32'(ack_log[t]), 32'h0);
        chk("midrst_ack1", 32'(ack_log[t+1]), 32'h0);
        cnt = 0;
        for (int c = a0 + 1; c <= a0 + 12; c++) cnt += resp_log[c];
        chk("midrst_no_resp", cnt, 32'd0);
        issue(1'b0, 32'h4, 32'h0, a1);
        step(8);
        chk("midrst_mem_resp", 32'(resp_log[a1+4]), 32'h1);
        chk("midrst_mem_clear", rdata_log[a1+4], 32'h0);

        // Request held for six cycles on the same write
`ifdef SLAVE_RESPONDER_THROTTLE_EN
        pat = 6'b101010;
`else
        pat = 6'b111111;
`endif
        req   = 1'b1;
        cmd   = 1'b1;
        addr  = 32'h10;
        wdata = 32'h5;
        s     = cyc;
        step(6);
        req = 1'b0;
        step(2);
        for (int k = 0; k < 6; k++) chk("held_ack_pattern", 32'(ack_log[s+k]), 32'(pat[5-k]));

        // Mixed traffic checked against the model every cycle
        for (int k = 0; k < 40; k++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, t);
            if ($urandom_range(0, 3) == 0) step(1);
        end
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
